// File: rtl/scr1_tcm_arb_pkg.sv
// Shared types for the TCM data-port arbiter: memory interface enums, master id and reset constants.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_tcm_arb_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_TCM_ARB_M0 = 1'b0,
        SCR1_TCM_ARB_M1 = 1'b1
    } type_scr1_tcm_arb_id_e;

    // Last-granted value out of reset, so that m0 wins the first contention.
    localparam type_scr1_tcm_arb_id_e SCR1_TCM_ARB_RR_RST = SCR1_TCM_ARB_M1;

    function automatic type_scr1_tcm_arb_id_e scr1_tcm_arb_other(input type_scr1_tcm_arb_id_e id);
        if (id == SCR1_TCM_ARB_M0) begin
            return SCR1_TCM_ARB_M1;
        end
        return SCR1_TCM_ARB_M0;
    endfunction

endpackage

// File: rtl/scr1_rr_arb2.sv
// Two-request round-robin grant; purely combinational, the last-grant register lives in the parent.
module scr1_rr_arb2
    import scr1_tcm_arb_pkg::*;
(
    input  logic [1:0]            req,
    input  type_scr1_tcm_arb_id_e rr_last,
    output logic                  gnt_vld,
    output type_scr1_tcm_arb_id_e gnt_id
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
        gnt_vld = |req;
        gnt_id  = SCR1_TCM_ARB_M0;
        if (req == 2'b11) begin
            gnt_id = scr1_tcm_arb_other(rr_last);
        end else if (req[1]) begin
            gnt_id = SCR1_TCM_ARB_M1;
        end
    end

endmodule

// File: rtl/scr1_tcm_dport_arb.sv
// Merges LSU (m0) and debug/DMA (m1) traffic onto TCM port B, one transfer in flight, response to owner.
// Optional out-of-window error path enabled by defining SCR1_TCM_ARB_ADDR_CHK_EN.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_tcm_dport_arb
    import scr1_tcm_arb_pkg::*;
#(
    parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_TCM_ARB_BASE = 32'hF000_0000,
    parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_TCM_ARB_SIZE = 32'h0001_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         m0_req,
    output logic                         m0_req_ack,
    input  type_scr1_mem_cmd_e           m0_cmd,
    input  type_scr1_mem_width_e         m0_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0] m0_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] m0_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0] m0_rdata,
    output type_scr1_mem_resp_e          m0_resp,

    input  logic                         m1_req,
    output logic                         m1_req_ack,
    input  type_scr1_mem_cmd_e           m1_cmd,
    input  type_scr1_mem_width_e         m1_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0] m1_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] m1_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0] m1_rdata,
    output type_scr1_mem_resp_e          m1_resp,

    output logic                         s_req,
    input  logic                         s_req_ack,
    output type_scr1_mem_cmd_e           s_cmd,
    output type_scr1_mem_width_e         s_width,
    output logic [`SCR1_DMEM_AWIDTH-1:0] s_addr,
    output logic [`SCR1_DMEM_DWIDTH-1:0] s_wdata,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] s_rdata,
    input  type_scr1_mem_resp_e          s_resp
);

    logic                          r_pend_vld;
    type_scr1_tcm_arb_id_e         r_pend_id;
    type_scr1_tcm_arb_id_e         r_rr_last;

    logic                          w_gnt_vld;
    type_scr1_tcm_arb_id_e         w_gnt_id;
    logic                          w_resp_done;
    logic                          w_issue_ok;
    logic                          w_fwd;
    logic                          w_accept;
    type_scr1_mem_resp_e           w_own_resp;
    logic [`SCR1_DMEM_DWIDTH-1:0]  w_own_rdata;

    scr1_rr_arb2 u_rr_arb (
        .req     ({m1_req, m0_req}),
        .rr_last (r_rr_last),
        .gnt_vld (w_gnt_vld),
        .gnt_id  (w_gnt_id)
    );

    always_comb begin
        if (w_gnt_id == SCR1_TCM_ARB_M1) begin
            s_cmd   = m1_cmd;
            s_width = m1_width;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end else begin
            s_cmd   = m0_cmd;
            s_width = m0_width;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end
    end

    // rst_n gates issue directly so nothing is forwarded or acked while reset is held.
    assign w_issue_ok = ~r_pend_vld | w_resp_done;
    assign w_fwd      = w_issue_ok & w_gnt_vld & rst_n;

`ifdef SCR1_TCM_ARB_ADDR_CHK_EN
    localparam logic [`SCR1_DMEM_AWIDTH-1:0] LP_WIN_MASK = ~(SCR1_TCM_ARB_SIZE - 1'b1);

    logic r_err_pend;
    logic w_addr_ok;

    assign w_addr_ok   = ((s_addr & LP_WIN_MASK) == SCR1_TCM_ARB_BASE);
    assign w_resp_done = r_pend_vld & ((s_resp != SCR1_MEM_RESP_NOTRDY) | r_err_pend);
    assign s_req       = w_fwd & w_addr_ok;
    // Out-of-window requests are accepted locally without waiting for the TCM.
    assign w_accept    = (s_req & s_req_ack) | (w_fwd & ~w_addr_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pend <= 1'b0;
        end else begin
            r_err_pend <= w_fwd & ~w_addr_ok;
        end
    end

    always_comb begin
        w_own_resp  = s_resp;
        w_own_rdata = s_rdata;
        if (r_err_pend) begin
            w_own_resp  = SCR1_MEM_RESP_RDY_ER;
            w_own_rdata = '0;
        end
    end
`else
    logic w_unused_cfg;

    // Window parameters only matter when the address check is built in.
    assign w_unused_cfg = ^{SCR1_TCM_ARB_BASE, SCR1_TCM_ARB_SIZE};
    assign w_resp_done  = r_pend_vld & (s_resp != SCR1_MEM_RESP_NOTRDY);
    assign s_req        = w_fwd;
    assign w_accept     = s_req & s_req_ack;

    always_comb begin
        w_own_resp  = s_resp;
        w_own_rdata = s_rdata;
    end
`endif

    assign m0_req_ack = w_accept & (w_gnt_id == SCR1_TCM_ARB_M0);
    assign m1_req_ack = w_accept & (w_gnt_id == SCR1_TCM_ARB_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_id  <= SCR1_TCM_ARB_M0;
            r_rr_last  <= SCR1_TCM_ARB_RR_RST;
        end else if (w_accept) begin
            r_pend_vld <= 1'b1;
            r_pend_id  <= w_gnt_id;
            r_rr_last  <= w_gnt_id;
        end else if (w_resp_done) begin
            r_pend_vld <= 1'b0;
        end
    end

    // Response path is combinational: the owner sees the TCM response in the cycle it arrives.
    always_comb begin
        m0_resp  = SCR1_MEM_RESP_NOTRDY;
        m0_rdata = '0;
        m1_resp  = SCR1_MEM_RESP_NOTRDY;
        m1_rdata = '0;
        if (r_pend_vld) begin
            if (r_pend_id == SCR1_TCM_ARB_M0) begin
                m0_resp  = w_own_resp;
                m0_rdata = w_own_rdata;
            end else begin
                m1_resp  = w_own_resp;
                m1_rdata = w_own_rdata;
            end
        end
    end

endmodule

// File: tb/tb_scr1_tcm_dport_arb.sv
// Self-checking bench for scr1_tcm_dport_arb: directed scenarios, then random traffic against a queue model.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module tb_scr1_tcm_dport_arb;
    import scr1_tcm_arb_pkg::*;

    localparam int AW = `SCR1_DMEM_AWIDTH;
    localparam int DW = `SCR1_DMEM_DWIDTH;
    localparam logic [AW-1:0] TB_BASE = '0;
    localparam logic [AW-1:0] TB_SIZE = 32'h0001_0000;
`ifdef SCR1_TCM_ARB_ADDR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic                 b_req   [2];
    type_scr1_mem_cmd_e   b_cmd   [2];
    type_scr1_mem_width_e b_width [2];
    logic [AW-1:0]        b_addr  [2];
    logic [DW-1:0]        b_wdata [2];

    logic                 m0_req_ack, m1_req_ack;
    logic [DW-1:0]        m0_rdata, m1_rdata;
    type_scr1_mem_resp_e  m0_resp, m1_resp;

    logic                 s_req, s_req_ack;
    type_scr1_mem_cmd_e   s_cmd;
    type_scr1_mem_width_e s_width;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_wdata, s_rdata;
    type_scr1_mem_resp_e  s_resp;

    int checks = 0;
    int errors = 0;

    // Slave (TCM stand-in) state and the parameters of its next response.
    bit                  sl_busy;
    int                  sl_cnt;
    type_scr1_mem_resp_e sl_kind;
    logic [DW-1:0]       sl_rdata;
    int                  nx_lat;
    type_scr1_mem_resp_e nx_kind;
    logic [DW-1:0]       nx_rdata;

    // Reference model: queue of in-flight owners, error flag of the head, last granted master.
    int m_q[$];
    bit m_err;
    int m_last;
    int e_win;
    bit e_fwd, e_acc, e_done, e_err;

    scr1_tcm_dport_arb #(
        .SCR1_TCM_ARB_BASE (TB_BASE),
        .SCR1_TCM_ARB_SIZE (TB_SIZE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (b_req[0]),
        .m0_req_ack (m0_req_ack),
        .m0_cmd     (b_cmd[0]),
        .m0_width   (b_width[0]),
        .m0_addr    (b_addr[0]),
        .m0_wdata   (b_wdata[0]),
        .m0_rdata   (m0_rdata),
        .m0_resp    (m0_resp),
        .m1_req     (b_req[1]),
        .m1_req_ack (m1_req_ack),
        .m1_cmd     (b_cmd[1]),
        .m1_width   (b_width[1]),
        .m1_addr    (b_addr[1]),
        .m1_wdata   (b_wdata[1]),
        .m1_rdata   (m1_rdata),
        .m1_resp    (m1_resp),
        .s_req      (s_req),
        .s_req_ack  (s_req_ack),
        .s_cmd      (s_cmd),
        .s_width    (s_width),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_resp     (s_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return 1 - last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic bit in_window(input logic [AW-1:0] a);
        return !CHK || ((a / TB_SIZE) == (TB_BASE / TB_SIZE));
    endfunction

    task automatic drive(input int x, input bit req, input type_scr1_mem_cmd_e cmd,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_req[x]   = req;
        b_cmd[x]   = cmd;
        b_width[x] = SCR1_MEM_WIDTH_WORD;
        b_addr[x]  = addr;
        b_wdata[x] = wd;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_err   = 1'b0;
        m_last  = 1;
        sl_busy = 1'b0;
        sl_cnt  = 0;
    endtask

    // Drive slave outputs for this cycle, let it settle, compare everything with the model.
    task automatic settle();
        int owner;
        bit can;
        if (sl_busy && sl_cnt == 0) begin
            s_resp  = sl_kind;
            s_rdata = sl_rdata;
        end else begin
            s_resp  = SCR1_MEM_RESP_NOTRDY;
            s_rdata = $urandom;
        end
        #1;
        owner  = (m_q.size() != 0) ? m_q[0] : -1;
        e_done = (owner >= 0) && (m_err || s_resp != SCR1_MEM_RESP_NOTRDY);
        can    = (owner < 0) || e_done;
        e_win  = can ? pick(b_req[0], b_req[1], m_last) : -1;
        e_err  = (e_win >= 0) && !in_window(b_addr[e_win]);
        e_fwd  = (e_win >= 0) && !e_err;
        e_acc  = (e_win >= 0) && (e_err || s_req_ack);
        check("s_req",  s_req,      e_fwd);
        check("m0_ack", m0_req_ack, e_acc && e_win == 0);
        check("m1_ack", m1_req_ack, e_acc && e_win == 1);
        check("m0_resp",  m0_resp,  (owner == 0) ? (m_err ? SCR1_MEM_RESP_RDY_ER : s_resp) : SCR1_MEM_RESP_NOTRDY);
        check("m1_resp",  m1_resp,  (owner == 1) ? (m_err ? SCR1_MEM_RESP_RDY_ER : s_resp) : SCR1_MEM_RESP_NOTRDY);
        check("m0_rdata", m0_rdata, (owner == 0 && !m_err) ? s_rdata : '0);
        check("m1_rdata", m1_rdata, (owner == 1 && !m_err) ? s_rdata : '0);
        if (e_fwd) begin
            check("s_cmd",   s_cmd,   b_cmd[e_win]);
            check("s_width", s_width, b_width[e_win]);
            check("s_addr",  s_addr,  b_addr[e_win]);
            check("s_wdata", s_wdata, b_wdata[e_win]);
        end
    endtask

    // Clock edge: advance model and slave, return at the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (e_done) begin
            void'(m_q.pop_front());
            m_err = 1'b0;
        end
        if (e_acc) begin
            m_q.push_back(e_win);
            m_last = e_win;
            m_err  = e_err;
        end
        if (sl_busy && sl_cnt == 0) sl_busy = 1'b0;
        else if (sl_busy) sl_cnt--;
        if (e_fwd && s_req_ack) begin
            sl_busy  = 1'b1;
            sl_cnt   = nx_lat - 1;
            sl_kind  = nx_kind;
            sl_rdata = nx_rdata;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        s_req_ack = 1'b1;
        s_resp    = SCR1_MEM_RESP_NOTRDY;
        s_rdata   = '0;
        nx_lat    = 1;
        nx_kind   = SCR1_MEM_RESP_RDY_OK;
        nx_rdata  = '0;
        model_reset();
        drive(0, 1'b1, SCR1_MEM_CMD_RD, 32'h0, '0);
        drive(1, 1'b1, SCR1_MEM_CMD_RD, 32'h4, '0);

        // Reset state with both masters requesting.
        #3;
        check("rst_s_req",  s_req,      1'b0);
        check("rst_m0_ack", m0_req_ack, 1'b0);
        check("rst_m1_ack", m1_req_ack, 1'b0);
        check("rst_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);
        check("rst_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
        check("rst_m0_rdata", m0_rdata, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Continuous contention: acks alternate starting with m0, response one cycle later.
        for (int i = 0; i < 6; i++) begin
            nx_rdata = $urandom;
            settle();
            check("t2_ack0", m0_req_ack, (i % 2) == 0);
            check("t2_ack1", m1_req_ack, (i % 2) == 1);
            if (i % 2 == 1) check("t2_resp0", m0_resp, SCR1_MEM_RESP_RDY_OK);
            else if (i > 0) check("t2_resp1", m1_resp, SCR1_MEM_RESP_RDY_OK);
            tick();
            if (e_acc) b_addr[e_win] = b_addr[e_win] + 32'h8;
        end
        b_req[0] = 1'b0;
        b_req[1] = 1'b0;
        settle();
        tick();

        // Single m0 read, TCM returns 0xDEADBEEF.
        drive(0, 1'b1, SCR1_MEM_CMD_RD, 32'h10, '0);
        nx_rdata = 32'hDEAD_BEEF;
        settle();
        check("t1_ack", m0_req_ack, 1'b1);
        check("t1_m1_resp_c0", m1_resp, SCR1_MEM_RESP_NOTRDY);
        tick();
        b_req[0] = 1'b0;
        settle();
        check("t1_resp",  m0_resp,  SCR1_MEM_RESP_RDY_OK);
        check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t1_m1_resp_c1", m1_resp, SCR1_MEM_RESP_NOTRDY);
        tick();

        // Slow slave: m1 write held three cycles, m0 waits and issues on the response cycle.
        nx_lat = 4;
        drive(1, 1'b1, SCR1_MEM_CMD_WR, 32'h20, 32'h1234_5678);
        settle();
        check("t3_m1_ack", m1_req_ack, 1'b1);
        tick();
        nx_lat = 1;
        b_req[1] = 1'b0;
        drive(0, 1'b1, SCR1_MEM_CMD_RD, 32'h30, '0);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("t3_hold_s_req", s_req,      1'b0);
            check("t3_hold_m0",    m0_req_ack, 1'b0);
            tick();
        end
        settle();
        check("t3_m1_resp", m1_resp,    SCR1_MEM_RESP_RDY_OK);
        check("t3_m0_ack",  m0_req_ack, 1'b1);
        check("t3_s_req",   s_req,      1'b1);
        tick();
        b_req[0] = 1'b0;
        settle();
        tick();

        // Slave error response on an m1 write, next request issued in the same cycle.
        nx_kind = SCR1_MEM_RESP_RDY_ER;
        drive(1, 1'b1, SCR1_MEM_CMD_WR, 32'h40, 32'hCAFE_0001);
        settle();
        check("t6_m1_ack", m1_req_ack, 1'b1);
        tick();
        nx_kind = SCR1_MEM_RESP_RDY_OK;
        b_req[1] = 1'b0;
        drive(0, 1'b1, SCR1_MEM_CMD_RD, 32'h44, '0);
        settle();
        check("t6_m1_resp", m1_resp,    SCR1_MEM_RESP_RDY_ER);
        check("t6_m0_ack",  m0_req_ack, 1'b1);
        check("t6_s_req",   s_req,      1'b1);
        tick();
        b_req[0] = 1'b0;
        settle();
        tick();

`ifdef SCR1_TCM_ARB_ADDR_CHK_EN
        // Out-of-window m1 read wins contention, is acked locally and completes with RDY_ER.
        drive(0, 1'b1, SCR1_MEM_CMD_RD, 32'h50, '0);
        drive(1, 1'b1, SCR1_MEM_CMD_RD, 32'h0002_0000, '0);
        settle();
        check("t5_m1_ack", m1_req_ack, 1'b1);
        check("t5_m0_ack", m0_req_ack, 1'b0);
        check("t5_s_req",  s_req,      1'b0);
        tick();
        b_req[1] = 1'b0;
        settle();
        check("t5_m1_resp",  m1_resp,    SCR1_MEM_RESP_RDY_ER);
        check("t5_m1_rdata", m1_rdata,   '0);
        check("t5_m0_ack",   m0_req_ack, 1'b1);
        check("t5_s_req_m0", s_req,      1'b1);
        tick();
        b_req[0] = 1'b0;
        settle();
        tick();
`endif

        // Reset while m0's response is on the bus: outputs drop immediately, m0 wins afterwards.
        drive(0, 1'b1, SCR1_MEM_CMD_RD, 32'h60, '0);
        settle();
        tick();
        b_req[0] = 1'b0;
        drive(1, 1'b1, SCR1_MEM_CMD_RD, 32'h64, '0);
        settle();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t4_m0_resp",  m0_resp,    SCR1_MEM_RESP_NOTRDY);
        check("t4_m1_resp",  m1_resp,    SCR1_MEM_RESP_NOTRDY);
        check("t4_m0_rdata", m0_rdata,   '0);
        check("t4_m0_ack",   m0_req_ack, 1'b0);
        check("t4_m1_ack",   m1_req_ack, 1'b0);
        check("t4_s_req",    s_req,      1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, SCR1_MEM_CMD_RD, 32'h68, '0);
        settle();
        check("t4_first_m0", m0_req_ack, 1'b1);
        check("t4_first_m1", m1_req_ack, 1'b0);
        tick();
        b_req[0] = 1'b0;

        // Random traffic: drops before ack, slow and erroring slave, occasional back-pressure.
        for (int n = 0; n < 3000; n++) begin
            for (int x = 0; x < 2; x++) begin
                if (!b_req[x]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        b_req[x]   = 1'b1;
                        b_cmd[x]   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
                        b_width[x] = type_scr1_mem_width_e'(2'($urandom_range(0, 2)));
                        b_addr[x]  = (CHK && $urandom_range(0, 4) == 0) ? AW'($urandom)
                                                                        : AW'($urandom_range(0, 32'hFFFF));
                        b_wdata[x] = $urandom;
                    end
                end else if ($urandom_range(0, 99) < 10) begin
                    b_req[x] = 1'b0;
                end
            end
            s_req_ack = ($urandom_range(0, 9) != 0);
            nx_lat    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1;
            nx_kind   = ($urandom_range(0, 6) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            nx_rdata  = $urandom;
            settle();
            tick();
            if (e_acc) b_req[e_win] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
